// File: rtl/prescaled_counter_if.sv
// Control and status bundle for prescaled_counter: the master drives the
// counter controls, the slave (the counter) returns count and pulses.
interface prescaled_counter_if #(
  parameter int unsigned PRESCALE_WIDTH = 22,
  parameter int unsigned WIDTH          = 8
);
  logic                      CE;
  logic [PRESCALE_WIDTH-1:0] DIV;
  logic [WIDTH-1:0]          MAX;
  logic                      UP;
  logic                      LOAD;
  logic [WIDTH-1:0]          LDVAL;
  logic [WIDTH-1:0]          O;
  logic                      TICK;
  logic                      COUT;

  modport master (
    output CE, DIV, MAX, UP, LOAD, LDVAL,
    input  O, TICK, COUT
  );

  modport slave (
    input  CE, DIV, MAX, UP, LOAD, LDVAL,
    output O, TICK, COUT
  );
endinterface

// File: rtl/prescaled_counter.sv
// Two-stage counter: a programmable prescaler emits a step tick and the main
// up/down modulo counter advances once per tick. All outputs are registered.
module prescaled_counter #(
  parameter int unsigned PRESCALE_WIDTH = 22,
  parameter int unsigned WIDTH          = 8
) (
  input  logic                CLK,
  input  logic                RESETN,
  prescaled_counter_if.slave  bus
);

  logic [PRESCALE_WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]          o_q, o_d;
  logic                      tick_q, tick_d;
  logic                      cout_q, cout_d;
  logic                      tick_int;
  logic [WIDTH-1:0]          load_val;

  // >= rather than == so that lowering DIV below P still ticks next cycle.
  assign tick_int = (p_q >= bus.DIV);
  assign load_val = (bus.LDVAL <= bus.MAX) ? bus.LDVAL : bus.MAX;

  always_comb begin
    p_d    = p_q;
    o_d    = o_q;
    tick_d = 1'b0;
    cout_d = 1'b0;
    if (bus.LOAD) begin
      o_d = load_val;
      p_d = '0;
    end else if (bus.CE) begin
      // P cannot overflow: at its all-ones value tick_int is always true.
      p_d    = tick_int ? '0 : p_q + 1'b1;
      tick_d = tick_int;
      if (tick_int) begin
        if (bus.UP) begin
          if (o_q >= bus.MAX) begin
            o_d    = '0;
            cout_d = 1'b1;
          end else begin
            o_d = o_q + 1'b1;
          end
        end else begin
          if (o_q == '0) begin
            o_d    = bus.MAX;
            cout_d = 1'b1;
          end else if (o_q > bus.MAX) begin
            o_d = bus.MAX;
          end else begin
            o_d = o_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      p_q    <= '0;
      o_q    <= '0;
      tick_q <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      o_q    <= o_d;
      tick_q <= tick_d;
      cout_q <= cout_d;
    end
  end

  assign bus.O    = o_q;
  assign bus.TICK = tick_q;
  assign bus.COUT = cout_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Self-checking bench for prescaled_counter: directed scenarios plus a
// randomized run, all compared against a behavioural model of the counter.
module tb_prescaled_counter;
  localparam int unsigned PW = 6;
  localparam int unsigned W  = 8;

  logic CLK = 1'b0;
  logic RESETN;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Behavioural model state.
  int unsigned m_p, m_o;
  logic        m_tick, m_cout;

  prescaled_counter_if #(.PRESCALE_WIDTH(PW), .WIDTH(W)) bus_if ();

  prescaled_counter #(.PRESCALE_WIDTH(PW), .WIDTH(W)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus_if)
  );

  always #5 CLK = ~CLK;

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    int unsigned dv, mx, lv;
    dv = bus_if.DIV;
    mx = bus_if.MAX;
    lv = bus_if.LDVAL;
    m_tick = 1'b0;
    m_cout = 1'b0;
    if (!RESETN) begin
      m_p = 0;
      m_o = 0;
    end else if (bus_if.LOAD) begin
      m_o = (lv > mx) ? mx : lv;
      m_p = 0;
    end else if (bus_if.CE) begin
      if (m_p >= dv) begin
        m_p    = 0;
        m_tick = 1'b1;
        if (bus_if.UP) begin
          if (m_o >= mx) begin
            m_o    = 0;
            m_cout = 1'b1;
          end else m_o = m_o + 1;
        end else begin
          if (m_o == 0) begin
            m_o    = mx;
            m_cout = 1'b1;
          end else if (m_o > mx) m_o = mx;
          else m_o = m_o - 1;
        end
      end else begin
        m_p = m_p + 1;
      end
    end
  endtask

  task automatic clk_step();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus_if.CE    = 1'b1;
      bus_if.LOAD  = 1'b1;
      bus_if.LDVAL = W'($urandom_range(1, 255));
      bus_if.MAX   = 8'd255;
      clk_step();
      n_checks++;
      if ({bus_if.O, bus_if.TICK, bus_if.COUT} !== 10'd0)
        $display("FAIL reset: got O=%0d TICK=%0b COUT=%0b, want 0/0/0",
                 bus_if.O, bus_if.TICK, bus_if.COUT);
      else n_pass++;
    end
    RESETN      = 1'b1;
    bus_if.LOAD = 1'b0;
  endtask

  task automatic test_basic_up();
    int couts = 0;
    bus_if.CE  = 1'b1;
    bus_if.DIV = PW'(3);
    bus_if.MAX = 8'd9;
    bus_if.UP  = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      clk_step();
      if (bus_if.COUT === 1'b1) couts++;
      n_checks++;
      if (bus_if.TICK !== ((c % 4) == 0))
        $display("FAIL basic_up_tick: cycle %0d got TICK=%0b, want %0b",
                 c, bus_if.TICK, (c % 4) == 0);
      else n_pass++;
      if (c == 4) begin
        n_checks++;
        if (bus_if.O !== 8'd1) $display("FAIL basic_up_first: got O=%0d, want 1", bus_if.O);
        else n_pass++;
      end
      if (c == 40) begin
        n_checks++;
        if ({bus_if.O, bus_if.COUT} !== 9'b0000_0000_1)
          $display("FAIL basic_up_wrap: got O=%0d COUT=%0b, want 0/1", bus_if.O, bus_if.COUT);
        else n_pass++;
      end
    end
    n_checks++;
    if (couts != 1) $display("FAIL basic_up_cout_count: got %0d pulses, want 1", couts);
    else n_pass++;
  endtask

  task automatic test_down_div0();
    logic [W-1:0] exp_o [4] = '{8'd1, 8'd0, 8'd5, 8'd4};
    logic         exp_c [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bus_if.DIV   = '0;
    bus_if.MAX   = 8'd5;
    bus_if.UP    = 1'b0;
    bus_if.LOAD  = 1'b1;
    bus_if.LDVAL = 8'd2;
    clk_step();
    bus_if.LOAD = 1'b0;
    n_checks++;
    if (bus_if.O !== 8'd2) $display("FAIL down_load: got O=%0d, want 2", bus_if.O);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      clk_step();
      n_checks++;
      if ({bus_if.O, bus_if.COUT} !== {exp_o[i], exp_c[i]})
        $display("FAIL down_seq[%0d]: got O=%0d COUT=%0b, want %0d/%0b",
                 i, bus_if.O, bus_if.COUT, exp_o[i], exp_c[i]);
      else n_pass++;
    end
  endtask

  task automatic test_load_priority();
    bus_if.DIV   = PW'(3);
    bus_if.MAX   = 8'd100;
    bus_if.UP    = 1'b1;
    bus_if.CE    = 1'b1;
    bus_if.LOAD  = 1'b1;
    bus_if.LDVAL = 8'd10;
    clk_step();
    bus_if.LOAD = 1'b0;
    for (int c = 0; c < 3; c++) clk_step();
    // Prescaler is now at DIV: this edge would tick without the load.
    bus_if.LOAD  = 1'b1;
    bus_if.LDVAL = 8'd200;
    bus_if.CE    = 1'b0;
    clk_step();
    n_checks++;
    if ({bus_if.O, bus_if.TICK, bus_if.COUT} !== {8'd100, 2'b00})
      $display("FAIL load_clip: got O=%0d TICK=%0b COUT=%0b, want 100/0/0",
               bus_if.O, bus_if.TICK, bus_if.COUT);
    else n_pass++;
    bus_if.LOAD = 1'b0;
    bus_if.CE   = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      clk_step();
      n_checks++;
      if ({bus_if.O, bus_if.TICK, bus_if.COUT} !== ((c == 4) ? {8'd0, 2'b11} : {8'd100, 2'b00}))
        $display("FAIL load_after[%0d]: got O=%0d TICK=%0b COUT=%0b",
                 c, bus_if.O, bus_if.TICK, bus_if.COUT);
      else n_pass++;
    end
  endtask

  task automatic test_ce_hold();
    bus_if.MAX   = 8'd9;
    bus_if.DIV   = PW'(3);
    bus_if.UP    = 1'b1;
    bus_if.CE    = 1'b1;
    bus_if.LOAD  = 1'b1;
    bus_if.LDVAL = 8'd3;
    clk_step();
    bus_if.LOAD = 1'b0;
    clk_step();
    clk_step();
    bus_if.CE = 1'b0;
    for (int c = 0; c < 7; c++) begin
      clk_step();
      n_checks++;
      if ({bus_if.O, bus_if.TICK, bus_if.COUT} !== {8'd3, 2'b00})
        $display("FAIL ce_hold[%0d]: got O=%0d TICK=%0b, want 3/0", c, bus_if.O, bus_if.TICK);
      else n_pass++;
    end
    bus_if.CE = 1'b1;
    clk_step();
    n_checks++;
    if (bus_if.TICK !== 1'b0) $display("FAIL ce_resume1: got TICK=%0b, want 0", bus_if.TICK);
    else n_pass++;
    clk_step();
    n_checks++;
    if ({bus_if.O, bus_if.TICK} !== {8'd4, 1'b1})
      $display("FAIL ce_resume2: got O=%0d TICK=%0b, want 4/1", bus_if.O, bus_if.TICK);
    else n_pass++;
  endtask

  task automatic test_max_shrink();
    for (int dir = 1; dir >= 0; dir--) begin
      bus_if.DIV   = '0;
      bus_if.MAX   = 8'd100;
      bus_if.UP    = dir[0];
      bus_if.CE    = 1'b0;
      bus_if.LOAD  = 1'b1;
      bus_if.LDVAL = 8'd50;
      clk_step();
      bus_if.LOAD = 1'b0;
      bus_if.MAX  = 8'd20;
      bus_if.CE   = 1'b1;
      clk_step();
      n_checks++;
      if ({bus_if.O, bus_if.TICK, bus_if.COUT} !== ((dir == 1) ? {8'd0, 2'b11} : {8'd20, 2'b10}))
        $display("FAIL max_shrink_up%0d: got O=%0d TICK=%0b COUT=%0b",
                 dir, bus_if.O, bus_if.TICK, bus_if.COUT);
      else n_pass++;
    end
  endtask

  task automatic test_full_scale();
    bus_if.MAX   = 8'd255;
    bus_if.DIV   = '0;
    bus_if.UP    = 1'b1;
    bus_if.CE    = 1'b0;
    bus_if.LOAD  = 1'b1;
    bus_if.LDVAL = 8'd255;
    clk_step();
    bus_if.LOAD = 1'b0;
    bus_if.CE   = 1'b1;
    clk_step();
    n_checks++;
    if ({bus_if.O, bus_if.COUT} !== {8'd0, 1'b1})
      $display("FAIL full_wrap: got O=%0d COUT=%0b, want 0/1", bus_if.O, bus_if.COUT);
    else n_pass++;
    // Full-scale prescaler: a tick only after 2^PW enabled cycles.
    bus_if.DIV   = '1;
    bus_if.LOAD  = 1'b1;
    bus_if.LDVAL = 8'd0;
    clk_step();
    bus_if.LOAD = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      clk_step();
      if (c >= 63) begin
        n_checks++;
        if ({bus_if.O, bus_if.TICK} !== ((c == 64) ? {8'd1, 1'b1} : {8'd0, 1'b0}))
          $display("FAIL full_div[%0d]: got O=%0d TICK=%0b", c, bus_if.O, bus_if.TICK);
        else n_pass++;
      end
    end
    bus_if.DIV = '0;
    clk_step();
    RESETN       = 1'b0;
    bus_if.LOAD  = 1'b1;
    bus_if.LDVAL = 8'd7;
    clk_step();
    n_checks++;
    if ({bus_if.O, bus_if.TICK, bus_if.COUT} !== 10'd0)
      $display("FAIL reset_over_load: got O=%0d TICK=%0b COUT=%0b, want 0/0/0",
               bus_if.O, bus_if.TICK, bus_if.COUT);
    else n_pass++;
    RESETN      = 1'b1;
    bus_if.LOAD = 1'b0;
  endtask

  task automatic test_random();
    int fails = 0;
    for (int c = 0; c < 3000; c++) begin
      RESETN       = ($urandom_range(0, 199) != 0);
      bus_if.CE    = ($urandom_range(0, 9) < 8);
      bus_if.LOAD  = ($urandom_range(0, 29) == 0);
      bus_if.LDVAL = W'($urandom);
      if ($urandom_range(0, 9) == 0) bus_if.UP = ~bus_if.UP;
      if ($urandom_range(0, 49) == 0)
        bus_if.DIV = ($urandom_range(0, 3) == 0) ? '1 : PW'($urandom_range(0, 4));
      if ($urandom_range(0, 49) == 0)
        case ($urandom_range(0, 3))
          0:       bus_if.MAX = 8'd0;
          1:       bus_if.MAX = 8'd255;
          default: bus_if.MAX = W'($urandom_range(1, 30));
        endcase
      clk_step();
      n_checks++;
      if ({bus_if.O, bus_if.TICK, bus_if.COUT} !== {W'(m_o), m_tick, m_cout}) begin
        if (fails < 10)
          $display("FAIL random[%0d]: got O=%0d TICK=%0b COUT=%0b, want %0d/%0b/%0b",
                   c, bus_if.O, bus_if.TICK, bus_if.COUT, m_o, m_tick, m_cout);
        fails++;
      end else n_pass++;
    end
  endtask

  initial begin
    m_p = 0;
    m_o = 0;
    m_tick = 1'b0;
    m_cout = 1'b0;
    RESETN       = 1'b0;
    bus_if.CE    = 1'b0;
    bus_if.DIV   = '0;
    bus_if.MAX   = '0;
    bus_if.UP    = 1'b1;
    bus_if.LOAD  = 1'b0;
    bus_if.LDVAL = '0;
    #1;
    test_reset();
    test_basic_up();
    test_down_div0();
    test_load_priority();
    test_ce_hold();
    test_max_shrink();
    test_full_scale();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
